// File: rtl/decode_rf_stage_pkg.sv
// Shared opcode, ALU-op and instruction-field definitions for the decode/register-fetch stage.
// Also holds the opcode decoder used by the stage.
package decode_rf_stage_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPC_LSB  = 24;
    localparam int unsigned DEST_LSB = 16;
    localparam int unsigned SRC1_LSB = 8;
    localparam int unsigned SRC2_LSB = 0;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;

    localparam logic [7:0] ALU_FWD = 8'd0;
    localparam logic [7:0] ALU_ADD = 8'd1;
    localparam logic [7:0] ALU_AND = 8'd2;
    localparam logic [7:0] ALU_OR  = 8'd3;

    typedef enum logic [1:0] {
        BSelImm,
        BSelRs1,
        BSelRs2,
        BSelNegRs2
    } b_sel_e;

    typedef struct packed {
        logic       legal;
        logic       reads_src;
        logic       uses_src2;
        logic       a_imm;
        b_sel_e     b_sel;
        logic [7:0] alu_op;
    } dec_t;

    function automatic dec_t decode_op(input logic [7:0] opcode);
        dec_t d;
        d = '{legal: 1'b1, reads_src: 1'b1, uses_src2: 1'b1, a_imm: 1'b0,
              b_sel: BSelRs2, alu_op: ALU_FWD};
        case (opcode)
            OP_LOADI: begin
                d.reads_src = 1'b0;
                d.uses_src2 = 1'b0;
                d.a_imm     = 1'b1;
                d.b_sel     = BSelImm;
            end
            OP_MOV: begin
                d.uses_src2 = 1'b0;
                d.b_sel     = BSelRs1;
            end
            OP_ADD: d.alu_op = ALU_ADD;
            // sub is an add of the two's complement of src2
            OP_SUB: begin
                d.alu_op = ALU_ADD;
                d.b_sel  = BSelNegRs2;
            end
            OP_AND: d.alu_op = ALU_AND;
            OP_OR:  d.alu_op = ALU_OR;
            default: begin
                d.legal     = 1'b0;
                d.reads_src = 1'b0;
                d.uses_src2 = 1'b0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_rf_stage_if.sv
// Instruction handshake, ALU, writeback and debug signals of the decode/register-fetch stage.
// slave is the stage itself; master is the surrounding fetch/ALU environment.
interface decode_rf_stage_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              illegal;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output instr, instr_valid, alu_res, dbg_addr,
        input  instr_ready, alu_op, alu_a, alu_b, wb_valid, wb_addr, wb_data, illegal, dbg_data
    );

    modport slave (
        input  instr, instr_valid, alu_res, dbg_addr,
        output instr_ready, alu_op, alu_a, alu_b, wb_valid, wb_addr, wb_data, illegal, dbg_data
    );
endinterface

// File: rtl/reg_file_8x8.sv
// General register file: two combinational read ports, a debug read port and one write port.
// Contents are cleared asynchronously on reset.
module reg_file_8x8 #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned REG_CNT = 8,
    parameter int unsigned ADDR_W  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);
    logic [DATA_W-1:0] mem_q [REG_CNT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < REG_CNT; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a  = mem_q[raddr_a];
    assign rdata_b  = mem_q[raddr_b];
    assign dbg_data = mem_q[dbg_addr];
endmodule

// File: rtl/decode_rf_stage.sv
// Decode/operand-fetch stage feeding the 8-bit ALU; writes the ALU result back one cycle later.
// Stalls for one cycle when the incoming instruction reads the register the EX slot will write.
module decode_rf_stage
    import decode_rf_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned REG_CNT = 8,
    parameter int unsigned ADDR_W  = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    decode_rf_stage_if.slave bus
);
    logic [7:0]        opcode;
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] a_d;
    logic [DATA_W-1:0] b_d;
    dec_t              dec;
    logic              hazard;
    logic              ready;
    logic              accept;

    logic              ex_valid_q;
    logic [ADDR_W-1:0] ex_dest_q;
    logic [7:0]        alu_op_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic              illegal_q;

    assign opcode = bus.instr[OPC_LSB +: 8];
    assign dest   = bus.instr[DEST_LSB +: ADDR_W];
    assign src1   = bus.instr[SRC1_LSB +: ADDR_W];
    assign src2   = bus.instr[SRC2_LSB +: ADDR_W];
    assign imm    = bus.instr[SRC2_LSB +: DATA_W];
    assign dec    = decode_op(opcode);

    logic unused_instr;
    assign unused_instr = ^{bus.instr[DEST_LSB+7:DEST_LSB+ADDR_W],
                            bus.instr[SRC1_LSB+7:SRC1_LSB+ADDR_W]};

    // EX retires unconditionally, so a hazard never lasts more than one cycle
    assign hazard = ex_valid_q & dec.reads_src &
                    ((src1 == ex_dest_q) | (dec.uses_src2 & (src2 == ex_dest_q)));
    assign ready  = reset_n & ~hazard;
    assign accept = bus.instr_valid & ready;

    reg_file_8x8 #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT),
        .ADDR_W  (ADDR_W)
    ) u_reg_file (
        .clk      (clk),
        .reset_n  (reset_n),
        .raddr_a  (src1),
        .rdata_a  (rs1_data),
        .raddr_b  (src2),
        .rdata_b  (rs2_data),
        .dbg_addr (bus.dbg_addr),
        .dbg_data (bus.dbg_data),
        .we       (ex_valid_q),
        .waddr    (ex_dest_q),
        .wdata    (bus.alu_res)
    );

    always_comb begin
        a_d = dec.a_imm ? imm : rs1_data;
        b_d = rs2_data;
        unique case (dec.b_sel)
            BSelImm:    b_d = imm;
            BSelRs1:    b_d = rs1_data;
            BSelRs2:    b_d = rs2_data;
            BSelNegRs2: b_d = (~rs2_data) + DATA_W'(1);
            default:    b_d = rs2_data;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q <= 1'b0;
            ex_dest_q  <= '0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            illegal_q  <= 1'b0;
        end else begin
            ex_valid_q <= accept & dec.legal;
            illegal_q  <= accept & ~dec.legal;
            // operands hold their last values when nothing legal is accepted
            if (accept && dec.legal) begin
                ex_dest_q <= dest;
                alu_op_q  <= dec.alu_op;
                alu_a_q   <= a_d;
                alu_b_q   <= b_d;
            end
        end
    end

    assign bus.instr_ready = ready;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.wb_valid    = ex_valid_q;
    assign bus.wb_addr     = ex_dest_q;
    assign bus.wb_data     = bus.alu_res;
    assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_decode_rf_stage.sv
// Bench for decode_rf_stage: directed vector table, hand-written corner sequences and random
// programs checked against a sequential instruction-set model.
module tb_decode_rf_stage;
    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad = 0;

    decode_rf_stage_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    decode_rf_stage #(.DATA_W(8), .REG_CNT(8), .ADDR_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    // The ALU downstream of the stage
    always_comb begin
        bus.alu_res = bus.alu_a;
        case (bus.alu_op)
            8'd0:    bus.alu_res = bus.alu_a;
            8'd1:    bus.alu_res = bus.alu_a + bus.alu_b;
            8'd2:    bus.alu_res = bus.alu_a & bus.alu_b;
            8'd3:    bus.alu_res = bus.alu_a | bus.alu_b;
            default: bus.alu_res = bus.alu_a;
        endcase
    end

    // Architectural model: registers updated in program order
    logic [7:0] mreg [8];
    logic [7:0] m_op, m_a, m_b;
    bit         ex_pending;
    int         ex_dest_m;

    typedef struct {
        logic [31:0] instr;
        int          stall;
        logic [7:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        ill;
    } vec_t;

    function automatic logic [31:0] enc(input logic [7:0] op, input logic [7:0] d,
                                        input logic [7:0] s1, input logic [7:0] s2);
        return {op, d, s1, s2};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
        m_op = 8'h00; m_a = 8'h00; m_b = 8'h00;
        ex_pending = 1'b0;
        ex_dest_m = 0;
    endtask

    // Present an instruction from a negedge, wait out any stall, return at the post-accept negedge
    task automatic issue(input logic [31:0] ins, output int stalls);
        logic [7:0] opc, imm, ra, rb, eop, ea, eb, res;
        int  d, s1, s2;
        bit  legal, reads, use2, exp_stall;
        opc = ins[31:24];
        imm = ins[7:0];
        d = int'(ins[18:16]);
        s1 = int'(ins[10:8]);
        s2 = int'(ins[2:0]);
        legal = (opc <= 8'd5);
        reads = legal && (opc != 8'd0);
        use2 = legal && (opc >= 8'd2);
        exp_stall = ex_pending && reads && (s1 == ex_dest_m || (use2 && s2 == ex_dest_m));
        stalls = 0;
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        #1;
        while (!bus.instr_ready && stalls < 4) begin
            @(negedge clk);
            stalls++;
        end
        if (!bus.instr_ready) begin
            $display("FAIL accept_timeout: got ready=0 required ready=1 at %0t", $time);
            bad++;
            total++;
        end
        chk("stall_cycles", stalls, {31'd0, exp_stall});
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        ra = mreg[s1];
        rb = mreg[s2];
        eop = 8'd0; ea = imm; eb = imm; res = imm;
        case (opc)
            8'd1: begin eop = 8'd0; ea = ra; eb = ra; res = ra; end
            8'd2: begin eop = 8'd1; ea = ra; eb = rb; res = ra + rb; end
            8'd3: begin eop = 8'd1; ea = ra; eb = 8'(256 - int'(rb)); res = ra - rb; end
            8'd4: begin eop = 8'd2; ea = ra; eb = rb; res = ra & rb; end
            8'd5: begin eop = 8'd3; ea = ra; eb = rb; res = ra | rb; end
            default: ;
        endcase
        if (legal) begin
            m_op = eop; m_a = ea; m_b = eb;
            chk("wb_valid", {31'd0, bus.wb_valid}, 32'd1);
            chk("wb_addr", {29'd0, bus.wb_addr}, d);
            chk("wb_data", {24'd0, bus.wb_data}, {24'd0, res});
            mreg[d] = res;
            ex_pending = 1'b1;
            ex_dest_m = d;
        end else begin
            chk("wb_valid_ill", {31'd0, bus.wb_valid}, 32'd0);
            ex_pending = 1'b0;
        end
        chk("alu_op", {24'd0, bus.alu_op}, {24'd0, m_op});
        chk("alu_a", {24'd0, bus.alu_a}, {24'd0, m_a});
        chk("alu_b", {24'd0, bus.alu_b}, {24'd0, m_b});
        chk("illegal", {31'd0, bus.illegal}, {31'd0, !legal});
    endtask

    task automatic idle(input int n);
        bus.instr_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk("idle_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
            chk("idle_illegal", {31'd0, bus.illegal}, 32'd0);
        end
        ex_pending = 1'b0;
    endtask

    // Reads all registers via the debug port within one half-cycle
    task automatic check_regs(input string name);
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr = 3'(i);
            #1;
            chk(name, {24'd0, bus.dbg_data}, {24'd0, mreg[i]});
        end
    endtask

    vec_t vecs [11];

    initial begin
        int st;
        reset_n = 1'b0;
        bus.instr = 32'd0;
        bus.instr_valid = 1'b0;
        bus.dbg_addr = 3'd0;
        model_reset();

        vecs[0]  = '{enc(8'h00, 8'd1, 8'd0, 8'h05), 0, 8'd0, 8'h05, 8'h05, 1'b0};
        vecs[1]  = '{enc(8'h00, 8'd2, 8'd0, 8'h09), 0, 8'd0, 8'h09, 8'h09, 1'b0};
        vecs[2]  = '{enc(8'h03, 8'd3, 8'd1, 8'd2),  1, 8'd1, 8'h05, 8'hF7, 1'b0};
        vecs[3]  = '{enc(8'h00, 8'd1, 8'd0, 8'hF0), 0, 8'd0, 8'hF0, 8'hF0, 1'b0};
        vecs[4]  = '{enc(8'h00, 8'd2, 8'd0, 8'h3C), 0, 8'd0, 8'h3C, 8'h3C, 1'b0};
        vecs[5]  = '{enc(8'h04, 8'd4, 8'd1, 8'd2),  1, 8'd2, 8'hF0, 8'h3C, 1'b0};
        vecs[6]  = '{enc(8'h05, 8'd5, 8'd1, 8'd2),  0, 8'd3, 8'hF0, 8'h3C, 1'b0};
        vecs[7]  = '{enc(8'h02, 8'd6, 8'd1, 8'd1),  0, 8'd1, 8'hF0, 8'hF0, 1'b0};
        vecs[8]  = '{enc(8'h01, 8'd7, 8'd4, 8'd0),  0, 8'd0, 8'h30, 8'h30, 1'b0};
        vecs[9]  = '{enc(8'h7E, 8'd2, 8'd1, 8'd1),  0, 8'd0, 8'h30, 8'h30, 1'b1};
        vecs[10] = '{enc(8'h00, 8'd0, 8'd0, 8'h11), 0, 8'd0, 8'h11, 8'h11, 1'b0};

        // Reset state
        #1;
        chk("rst_ready", {31'd0, bus.instr_ready}, 32'd0);
        chk("rst_alu_op", {24'd0, bus.alu_op}, 32'd0);
        chk("rst_alu_a", {24'd0, bus.alu_a}, 32'd0);
        chk("rst_alu_b", {24'd0, bus.alu_b}, 32'd0);
        chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check_regs("rst_reg");
        @(negedge clk);
        reset_n = 1'b1;

        // Directed program
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].instr, st);
            chk($sformatf("vec%0d_stall", i), st, vecs[i].stall);
            chk($sformatf("vec%0d_op", i), {24'd0, bus.alu_op}, {24'd0, vecs[i].op});
            chk($sformatf("vec%0d_a", i), {24'd0, bus.alu_a}, {24'd0, vecs[i].a});
            chk($sformatf("vec%0d_b", i), {24'd0, bus.alu_b}, {24'd0, vecs[i].b});
            chk($sformatf("vec%0d_ill", i), {31'd0, bus.illegal}, {31'd0, vecs[i].ill});
        end
        idle(1);
        check_regs("vec_regs");
        bus.dbg_addr = 3'd3;
        #1;
        chk("sub_r3", {24'd0, bus.dbg_data}, 32'hFC);
        bus.dbg_addr = 3'd6;
        #1;
        chk("add_wrap_r6", {24'd0, bus.dbg_data}, 32'hE0);

        // loadi then a dependent add back-to-back: exactly one stall cycle
        @(negedge clk);
        ex_pending = 1'b0;
        issue(enc(8'h00, 8'd1, 8'd0, 8'h0F), st);
        issue(enc(8'h02, 8'd2, 8'd1, 8'd1), st);
        chk("raw_stall_once", st, 1);
        idle(1);
        bus.dbg_addr = 3'd2;
        #1;
        chk("raw_r2", {24'd0, bus.dbg_data}, 32'h1E);

        // Illegal opcode followed immediately by a legal one
        @(negedge clk);
        ex_pending = 1'b0;
        issue(enc(8'h7E, 8'd3, 8'd3, 8'd3), st);
        issue(enc(8'h00, 8'd5, 8'd0, 8'h66), st);
        chk("after_ill_stall", st, 0);
        chk("ill_pulse_end", {31'd0, bus.illegal}, 32'd0);
        idle(1);
        check_regs("ill_regs");

        // Reset while loadi R7,0xAA sits in EX
        @(negedge clk);
        ex_pending = 1'b0;
        issue(enc(8'h00, 8'd7, 8'd0, 8'hAA), st);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_ready", {31'd0, bus.instr_ready}, 32'd0);
        chk("mid_rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("mid_rst_alu_a", {24'd0, bus.alu_a}, 32'd0);
        bus.instr = enc(8'h00, 8'd1, 8'd0, 8'h22);
        bus.instr_valid = 1'b1;
        @(negedge clk);
        chk("held_rst_ready", {31'd0, bus.instr_ready}, 32'd0);
        check_regs("mid_rst_regs");
        @(negedge clk);
        reset_n = 1'b1;
        issue(enc(8'h00, 8'd1, 8'd0, 8'h22), st);
        chk("first_accept_stall", st, 0);

        // Random programs against the model
        for (int n = 0; n < 300; n++) begin
            logic [7:0] opc;
            int r;
            r = $urandom_range(0, 9);
            opc = (r <= 5) ? 8'(r) : 8'($urandom_range(6, 255));
            issue(enc(opc, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255))), st);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);
        check_regs("rand_regs");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_rf_stage.md
Name: decode_rf_stage

Overview:
- Decode/operand-fetch stage directly upstream of the 8-bit ALU.
- Accepts 32-bit instruction words over a valid/ready handshake and reads an internal 8x8 register file.
- Drives registered ALU op/operands, then writes the ALU result back into the register file one cycle later.
- Stalls on read-after-write hazards against the instruction currently in execute.

Parameters:
- DATA_W, 8, register and ALU operand width
- REG_CNT, 8, number of general registers
- ADDR_W, 3, register index width; only instr field bits [ADDR_W-1:0] are used

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- instr  input  32  [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2 or immediate
- instr_valid  input  1  instr is presented
- instr_ready  output  1  stage accepts instr this cycle
- alu_op  output  8  ALU opcode (registered)
- alu_a  output  DATA_W  ALU operand A (registered)
- alu_b  output  DATA_W  ALU operand B (registered)
- alu_res  input  DATA_W  combinational ALU result for the current alu_op/alu_a/alu_b
- wb_valid  output  1  writeback occurs at this clock edge
- wb_addr  output  ADDR_W  writeback register index
- wb_data  output  DATA_W  writeback data (= alu_res)
- illegal  output  1  one-cycle pulse after an undefined opcode is accepted
- dbg_addr  input  ADDR_W  debug register read index
- dbg_data  output  DATA_W  combinational R[dbg_addr]

Behaviour:
- Opcodes: 0x00 loadi, 0x01 mov, 0x02 add, 0x03 sub, 0x04 and, 0x05 or; all others are illegal.
- Decode mapping (ALU opcodes zero-extended to 8 bits):
  - loadi: alu_op=0, alu_a=alu_b=imm.
  - mov: alu_op=0, alu_a=alu_b=R[src1].
  - add: alu_op=1, a=R[src1], b=R[src2].
  - sub: alu_op=1, a=R[src1], b=(~R[src2])+1 (two's complement, mod 2^DATA_W).
  - and: alu_op=2.
  - or: alu_op=3.
- Handshake and timing:
  - Transfer when instr_valid & instr_ready at a rising edge.
  - Operands are captured into the EX registers at that edge and ex_valid is set.
  - During the following cycle, alu_res is valid; wb_valid=ex_valid, wb_addr=ex_dest, wb_data=alu_res.
  - R[ex_dest]<=alu_res at the next edge.
  - Accept-to-regfile-update latency: 2 edges.
  - Throughput: 1 instruction/cycle with no hazard.
- Hazard stall:
  - instr_ready = ~(ex_valid & reads_src & (src1==ex_dest | (src2==ex_dest & uses_src2))).
  - loadi reads nothing and never stalls; mov uses src1 only.
  - Stall lasts exactly 1 cycle, because EX retires unconditionally.
- EX register update:
  - If no transfer at an edge, ex_valid<=0.
  - alu_op/alu_a/alu_b hold their last values and are not zeroed.
- Illegal opcode:
  - The instruction is consumed (ready follows the rules above with no source reads).
  - ex_valid<=0, no register written, illegal=1 for the next cycle only.
- Register file and debug port:
  - Writes occur only via EX writeback.
  - Register 0 is an ordinary register.
  - dbg_data reflects the array state as of the last edge.
- Reset (async, reset_n=0):
  - All registers, alu_op, alu_a and alu_b cleared to 0; ex_valid=0; illegal=0; wb_valid=0.
  - instr_ready=0 while reset_n=0.
  - Reset asserted mid-operation discards the in-flight EX instruction with no writeback.
  - First accept is possible at the first edge after deassertion.
- Back-to-back writes to the same dest: the later one wins, ordered by EX retirement.

Decomposition:
- Shared package: opcode constants (OP_LOADI..OP_OR), ALU op constants (ALU_FWD=0, ALU_ADD=1, ALU_AND=2, ALU_OR=3), and instruction field bit positions.
- One natural sub-module: reg_file_8x8.
  - Ports: clk, reset_n, two combinational read ports plus a debug read port, one write port.
  - Async clear on reset.

Test Plan:
- Reset then loadi R1,0x05 -> alu_op=0, alu_a=alu_b=0x05 next cycle; wb_valid=1, wb_addr=1; dbg R1=0x05 two edges after accept.
- loadi R1,5; loadi R2,9; sub R3,R1,R2 -> alu_b=0xF7 with alu_op=1; R3=0xFC.
- loadi R1,0x0F; add R2,R1,R1 issued back-to-back -> instr_ready=0 for exactly 1 cycle; R2=0x1E.
- R1=0xF0, R2=0x3C: and R4,R1,R2 -> 0x30; or R5,R1,R2 -> 0xFC; add R6,R1,R1 -> 0xE0 (wrap).
- Opcode 0x7E accepted -> illegal pulses 1 cycle, wb_valid stays 0, all registers unchanged; next legal instr accepted immediately.
- Assert reset_n=0 in the cycle after accepting loadi R7,0xAA -> R7 reads 0x00, wb_valid=0, instr_ready=0 until release.
